// File: rtl/alu_op_queue.sv
// Operand queue in front of a combinational ALU, with a registered valid/ready result stage.
// Optional macro ALU_OP_QUEUE_ILLEGAL_CHECK_EN adds out_err and zeroes results of unknown control codes.
module alu_op_queue #(
    parameter int DEPTH  = 4,
    parameter int WIDTH  = 32,
    parameter int CTRL_W = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [WIDTH-1:0]       in_a,
    input  logic [WIDTH-1:0]       in_b,
    input  logic [CTRL_W-1:0]      in_ctrl,
    output logic [WIDTH-1:0]       ALU_A,
    output logic [WIDTH-1:0]       ALU_B,
    output logic [CTRL_W-1:0]      ALU_control,
    input  logic [WIDTH-1:0]       alu_result,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WIDTH-1:0]       out_result,
    output logic [CTRL_W-1:0]      out_ctrl,
    output logic [$clog2(DEPTH):0] count
`ifdef ALU_OP_QUEUE_ILLEGAL_CHECK_EN
    ,
    output logic                   out_err
`endif
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [WIDTH-1:0]  mem_a [DEPTH];
    logic [WIDTH-1:0]  mem_b [DEPTH];
    logic [CTRL_W-1:0] mem_c [DEPTH];

    logic [CW-1:0]     count_q, count_d;
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic              out_valid_q, out_valid_d;
    logic [WIDTH-1:0]  out_result_q, out_result_d;
    logic [CTRL_W-1:0] out_ctrl_q, out_ctrl_d;
    logic              empty, push, pop;

    assign empty    = (count_q == '0);
    assign in_ready = (count_q < FULL_CNT);
    assign push     = in_valid && in_ready;
    // in_ready looks only at count, so a pop cannot open a slot in the same cycle
    assign pop      = !empty && (!out_valid_q || out_ready);

    assign ALU_A       = empty ? '0 : mem_a[rd_ptr_q];
    assign ALU_B       = empty ? '0 : mem_b[rd_ptr_q];
    assign ALU_control = empty ? '0 : mem_c[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (push) begin
            mem_a[wr_ptr_q] <= in_a;
            mem_b[wr_ptr_q] <= in_b;
            mem_c[wr_ptr_q] <= in_ctrl;
        end
    end

`ifdef ALU_OP_QUEUE_ILLEGAL_CHECK_EN
    logic out_err_q, out_err_d;
    logic head_legal;

    assign head_legal = (ALU_control == CTRL_W'(0)) || (ALU_control == CTRL_W'(1));
    assign out_err    = out_err_q;
`endif

    always_comb begin
        count_d      = count_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        out_valid_d  = out_valid_q;
        out_result_d = out_result_q;
        out_ctrl_d   = out_ctrl_q;
`ifdef ALU_OP_QUEUE_ILLEGAL_CHECK_EN
        out_err_d    = out_err_q;
`endif
        if (push) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        unique case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        if (pop) begin
            rd_ptr_d     = rd_ptr_q + PW'(1);
            out_valid_d  = 1'b1;
            out_result_d = alu_result;
            out_ctrl_d   = ALU_control;
`ifdef ALU_OP_QUEUE_ILLEGAL_CHECK_EN
            out_err_d    = !head_legal;
            if (!head_legal) begin
                out_result_d = '0;
            end
`endif
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q      <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            out_valid_q  <= 1'b0;
            out_result_q <= '0;
            out_ctrl_q   <= '0;
`ifdef ALU_OP_QUEUE_ILLEGAL_CHECK_EN
            out_err_q    <= 1'b0;
`endif
        end else begin
            count_q      <= count_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            out_valid_q  <= out_valid_d;
            out_result_q <= out_result_d;
            out_ctrl_q   <= out_ctrl_d;
`ifdef ALU_OP_QUEUE_ILLEGAL_CHECK_EN
            out_err_q    <= out_err_d;
`endif
        end
    end

    assign count      = count_q;
    assign out_valid  = out_valid_q;
    assign out_result = out_result_q;
    assign out_ctrl   = out_ctrl_q;

endmodule

// File: tb/tb_alu_op_queue.sv
// Self-checking bench for alu_op_queue: vector table, directed corner sequences and a random scoreboard run.
module tb_alu_op_queue;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_a, in_b;
    logic [3:0]  in_ctrl;
    logic [31:0] ALU_A, ALU_B;
    logic [3:0]  ALU_control;
    logic [31:0] alu_result;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic [3:0]  out_ctrl;
    logic [2:0]  count;
`ifdef ALU_OP_QUEUE_ILLEGAL_CHECK_EN
    logic        out_err;
`endif

    int checks   = 0;
    int failures = 0;

    alu_op_queue #(.DEPTH(4), .WIDTH(32), .CTRL_W(4)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_ctrl(in_ctrl),
        .ALU_A(ALU_A), .ALU_B(ALU_B), .ALU_control(ALU_control),
        .alu_result(alu_result),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_ctrl(out_ctrl),
        .count(count)
`ifdef ALU_OP_QUEUE_ILLEGAL_CHECK_EN
        , .out_err(out_err)
`endif
    );

    // Stand-in ALU: AND, OR, and XOR for any other code so unknown codes give a visible value
    assign alu_result = (ALU_control == 4'd0) ? (ALU_A & ALU_B) :
                        (ALU_control == 4'd1) ? (ALU_A | ALU_B) : (ALU_A ^ ALU_B);

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  ctrl;
        logic [31:0] exp;
    } vec_t;

    typedef struct {
        logic [31:0] res;
        logic [3:0]  ctrl;
    } exp_t;

    vec_t vecs[6];
    exp_t sb[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] b, input logic [3:0] c);
        in_valid = v;
        in_a     = a;
        in_b     = b;
        in_ctrl  = c;
    endtask

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        int          accepted;
        int          cycles;
        int          occ;
        bit          hold;
        logic [31:0] hold_res;
        logic [3:0]  hold_ctrl;
        logic [31:0] ra, rb;
        logic [3:0]  rc;

        vecs[0] = '{32'hFFFF_0000, 32'h00FF_FF00, 4'd0, 32'h00FF_0000};
        vecs[1] = '{32'hFFFF_0000, 32'h00FF_FF00, 4'd1, 32'hFFFF_FF00};
        vecs[2] = '{32'h0000_0000, 32'h0000_0000, 4'd1, 32'h0000_0000};
        vecs[3] = '{32'h1234_5678, 32'hFFFF_FFFF, 4'd0, 32'h1234_5678};
        vecs[4] = '{32'hA5A5_A5A5, 32'h5A5A_5A5A, 4'd1, 32'hFFFF_FFFF};
        vecs[5] = '{32'hA5A5_A5A5, 32'h5A5A_5A5A, 4'd0, 32'h0000_0000};

        reset     = 1'b1;
        out_ready = 1'b0;
        drive(1'b0, 32'h0, 32'h0, 4'h0);
        repeat (2) @(negedge clk);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_result", out_result, 32'd0);
        chk("rst_out_ctrl", 32'(out_ctrl), 32'd0);
        chk("rst_alu_a", ALU_A, 32'd0);
`ifdef ALU_OP_QUEUE_ILLEGAL_CHECK_EN
        chk("rst_out_err", 32'(out_err), 32'd0);
`endif
        reset = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd1);

        // First op: two-edge latency, no empty bypass
        out_ready = 1'b1;
        drive(1'b1, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 4'd0);
        tick;
        drive(1'b0, 32'h0, 32'h0, 4'h0);
        chk("lat_edge1_valid", 32'(out_valid), 32'd0);
        chk("lat_edge1_count", 32'(count), 32'd1);
        chk("lat_edge1_alu_a", ALU_A, 32'hF0F0_F0F0);
        tick;
        chk("lat_edge2_valid", 32'(out_valid), 32'd1);
        chk("lat_edge2_result", out_result, 32'h00F0_00F0);
        chk("lat_edge2_ctrl", 32'(out_ctrl), 32'd0);
        chk("lat_edge2_count", 32'(count), 32'd0);
        tick;

        for (int i = 0; i < 6; i++) begin
            drive(1'b1, vecs[i].a, vecs[i].b, vecs[i].ctrl);
            tick;
            drive(1'b0, 32'h0, 32'h0, 4'h0);
            tick;
            chk($sformatf("vec%0d_valid", i), 32'(out_valid), 32'd1);
            chk($sformatf("vec%0d_result", i), out_result, vecs[i].exp);
            chk($sformatf("vec%0d_ctrl", i), 32'(out_ctrl), 32'(vecs[i].ctrl));
        end
        tick;
        chk("vec_drain_valid", 32'(out_valid), 32'd0);

        // Fill under backpressure; the 6th op must be refused
        out_ready = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            drive(1'b1, 32'h100 + 32'(i), 32'hFFFF_FFFF, 4'd0);
            if (i == 5) begin
                chk("bp5_in_ready", 32'(in_ready), 32'd1);
                chk("bp5_count", 32'(count), 32'd3);
            end
            if (i == 6) begin
                chk("bp6_in_ready", 32'(in_ready), 32'd0);
                chk("bp6_count", 32'(count), 32'd4);
            end
            tick;
        end
        chk("full_count", 32'(count), 32'd4);
        chk("full_out_valid", 32'(out_valid), 32'd1);
        chk("full_out_result", out_result, 32'h101);
        chk("full_head", ALU_A, 32'h102);
        out_ready = 1'b1;
        chk("full_pop_in_ready", 32'(in_ready), 32'd0);
        tick;
        chk("after_full_pop_count", 32'(count), 32'd3);
        chk("after_full_pop_in_ready", 32'(in_ready), 32'd1);
        chk("after_full_pop_result", out_result, 32'h102);
        drive(1'b0, 32'h0, 32'h0, 4'h0);
        for (int k = 3; k <= 5; k++) begin
            tick;
            chk($sformatf("bp_order%0d_valid", k), 32'(out_valid), 32'd1);
            chk($sformatf("bp_order%0d_result", k), out_result, 32'h100 + 32'(k));
        end
        tick;
        chk("bp_drain_valid", 32'(out_valid), 32'd0);
        chk("bp_drain_result_held", out_result, 32'h105);
        chk("bp_drain_count", 32'(count), 32'd0);

        // Sustained stream of 16 OR ops with the consumer always ready
        for (int t = 0; t < 18; t++) begin
            if (t < 16) drive(1'b1, 32'(t), 32'h100, 4'd1);
            else        drive(1'b0, 32'h0, 32'h0, 4'h0);
            tick;
            chk($sformatf("stream%0d_valid", t), 32'(out_valid), 32'((t >= 1) && (t <= 16)));
            if (t >= 1 && t <= 16)
                chk($sformatf("stream%0d_result", t), out_result, 32'(t - 1) | 32'h100);
        end

        // Random traffic against an in-order scoreboard
        accepted = 0;
        cycles   = 0;
        hold     = 1'b0;
        hold_res = '0;
        hold_ctrl = '0;
        while ((accepted < 200 || sb.size() > 0) && cycles < 6000) begin
            occ = int'(count) + int'(out_valid);
            chk("rnd_occupancy", 32'(occ), 32'(sb.size()));
            if (hold) begin
                chk("rnd_hold_valid", 32'(out_valid), 32'd1);
                chk("rnd_hold_result", out_result, hold_res);
                chk("rnd_hold_ctrl", 32'(out_ctrl), 32'(hold_ctrl));
            end
            ra = $urandom;
            rb = $urandom;
            rc = 4'($urandom_range(0, 1));
            drive((accepted < 200) && ($urandom_range(0, 3) != 0), ra, rb, rc);
            out_ready = ($urandom_range(0, 1) == 1);
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    chk("rnd_unexpected_result", 32'(out_valid), 32'd0);
                end else begin
                    chk("rnd_result", out_result, sb[0].res);
                    chk("rnd_ctrl", 32'(out_ctrl), 32'(sb[0].ctrl));
                    void'(sb.pop_front());
                end
            end
            if (in_valid && in_ready) begin
                sb.push_back('{(rc == 4'd0) ? (ra & rb) : (ra | rb), rc});
                accepted++;
            end
            hold      = out_valid && !out_ready;
            hold_res  = out_result;
            hold_ctrl = out_ctrl;
            tick;
            cycles++;
        end
        chk("rnd_accepted", 32'(accepted), 32'd200);
        chk("rnd_drained", 32'(sb.size()), 32'd0);

        // Asynchronous reset while the queue holds data
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 32'h200 + 32'(i), 32'hFFFF_FFFF, 4'd0);
            tick;
        end
        drive(1'b0, 32'h0, 32'h0, 4'h0);
        chk("pre_rst_count", 32'(count), 32'd3);
        chk("pre_rst_out_valid", 32'(out_valid), 32'd1);
        #2 reset = 1'b1;
        #1;
        chk("async_rst_count", 32'(count), 32'd0);
        chk("async_rst_out_valid", 32'(out_valid), 32'd0);
        chk("async_rst_out_result", out_result, 32'd0);
        chk("async_rst_out_ctrl", 32'(out_ctrl), 32'd0);
        chk("async_rst_alu_a", ALU_A, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        out_ready = 1'b1;
        drive(1'b1, 32'hAAAA_0000, 32'hFFFF_0000, 4'd0);
        tick;
        drive(1'b0, 32'h0, 32'h0, 4'h0);
        tick;
        chk("post_rst_result", out_result, 32'hAAAA_0000);
        chk("post_rst_count", 32'(count), 32'd0);
        tick;

        // Control code outside AND/OR
        drive(1'b1, 32'h0000_FFFF, 32'h00FF_00FF, 4'b0111);
        tick;
        drive(1'b0, 32'h0, 32'h0, 4'h0);
        tick;
        chk("illegal_valid", 32'(out_valid), 32'd1);
        chk("illegal_ctrl", 32'(out_ctrl), 32'h7);
`ifdef ALU_OP_QUEUE_ILLEGAL_CHECK_EN
        chk("illegal_err", 32'(out_err), 32'd1);
        chk("illegal_result", out_result, 32'd0);
        drive(1'b1, 32'h0000_FFFF, 32'h00FF_00FF, 4'd1);
        tick;
        drive(1'b0, 32'h0, 32'h0, 4'h0);
        tick;
        chk("legal_err", 32'(out_err), 32'd0);
        chk("legal_result", out_result, 32'h00FF_FFFF);
`else
        chk("illegal_passthru", out_result, 32'h00FF_FF00);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_op_queue.md
Name: alu_op_queue

Overview:
- Issue stage that sits directly upstream of the combinational 32-bit ALU and also captures its result.
- Buffers incoming operand/control triples in a DEPTH-entry FIFO and drives the head entry onto the ALU inputs.
- Registers the ALU result into an output stage with valid/ready backpressure.
- Decouples the decode/register-read producer from the writeback consumer.

Parameters:
- DEPTH, 4, FIFO entries; power of two, >= 2
- WIDTH, 32, operand/result width; matches ALU datapath
- CTRL_W, 4, ALU control code width

Ports:
- clk  input  1  system clock; all state updates on rising edge
- reset  input  1  asynchronous, active-high reset
- in_valid  input  1  producer offers an operation
- in_ready  output  1  queue can accept; equals (count < DEPTH)
- in_a  input  WIDTH  operand A
- in_b  input  WIDTH  operand B
- in_ctrl  input  CTRL_W  ALU control code (0000 AND, 0001 OR)
- ALU_A  output  WIDTH  head operand A to ALU
- ALU_B  output  WIDTH  head operand B to ALU
- ALU_control  output  CTRL_W  head control code to ALU
- alu_result  input  WIDTH  combinational result returned by ALU
- out_valid  output  1  out_result holds a completed result
- out_ready  input  1  consumer accepts result
- out_result  output  WIDTH  registered ALU result
- out_ctrl  output  CTRL_W  control code that produced out_result
- count  output  $clog2(DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset (async, active-high):
  - count=0; read/write pointers=0.
  - out_valid=0, out_result=0, out_ctrl=0.
  - in_ready=1 once reset deasserts.
  - A reset asserted mid-operation discards all queued entries and any held result immediately, without waiting for a clock edge.
- Push: in_valid && in_ready at a clock edge writes {in_a, in_b, in_ctrl} at wr_ptr; wr_ptr increments modulo DEPTH.
- Head drive:
  - ALU_A/ALU_B/ALU_control come combinationally from storage at rd_ptr when count>0.
  - When count==0 they are forced to 0.
- Pop/capture condition: pop = (count>0) && (!out_valid || out_ready). On pop at a clock edge:
  - out_result <= alu_result, out_ctrl <= head ctrl, out_valid <= 1.
  - rd_ptr increments modulo DEPTH.
- Drain: out_valid && out_ready && !pop -> out_valid <= 0. out_result/out_ctrl keep their last value.
- Hold: out_valid && !out_ready -> out_result/out_ctrl/out_valid stable; no pop.
- Occupancy:
  - push && !pop -> count+1
  - pop && !push -> count-1
  - push && pop -> count unchanged, including at count==DEPTH-1 and count==1.
- Full: in_ready=0 at count==DEPTH, even if a pop occurs the same cycle (no full-bypass). in_valid while full is ignored; no overwrite.
- Empty bypass: none. An op pushed at edge N becomes head after N and is captured at edge N+1 at earliest. Minimum latency from in handshake to out_valid is 2 edges.
- Throughput: 1 op/cycle sustained when out_ready held high.
- Pointer wrap: pointers are $clog2(DEPTH) bits and wrap naturally; count disambiguates full vs empty.
- Control codes other than 0000/0001 are passed to the ALU unchanged; result is whatever the ALU returns (may be X in simulation).
- No combinational path from in_* to out_* or from out_ready to in_ready.

Optional Feature:
- Macro ALU_OP_QUEUE_ILLEGAL_CHECK_EN.
- When defined:
  - Adds output port out_err (1 bit, reset 0), updated on every pop.
  - out_err <= 1 when head ctrl is not 0000/0001; out_result is then forced to 0 instead of alu_result.
  - out_err <= 0 otherwise; holds with out_result.
- When undefined: no out_err port; alu_result is always captured unmodified.

Test Plan:
- Reset, then push A=32'hF0F0_F0F0, B=32'h0FF0_0FF0, ctrl=0000 with out_ready=1 -> out_valid at 2nd edge, out_result=32'h00F0_00F0, out_ctrl=0000, count returns to 0.
- Push 4 ops back-to-back with out_ready=0:
  - 1st op is captured into the output register; remaining 3 queue.
  - 5th push: in_ready stays 1 (count=3).
  - 6th push: count=4, in_ready=0; the 6th op is not accepted (no overwrite).
  - Then raise out_ready -> results emerge in push order, one per cycle.
- Stream 16 OR ops (A=i, B=32'h100) with out_ready=1 continuously -> 16 consecutive out_valid cycles, out_result=i|32'h100, pointers wrap 4 times, no gaps.
- Simultaneous push and pop at count=DEPTH with out_ready=1:
  - in_ready=0 blocks the push.
  - Count drops to 3, then in_ready=1 next cycle.
- Toggle out_ready randomly for 200 random ops -> scoreboard matches AND/OR results in order; out_result stable while out_valid && !out_ready.
- Assert reset mid-stream with count=3 and out_valid=1 -> out_valid, out_result, and count go to 0 immediately (before next edge); with ALU_OP_QUEUE_ILLEGAL_CHECK_EN, push ctrl=0111 -> out_err=1, out_result=0.
